j1_io_responder: RTL and testbench

I/O-space responder for the J1 core. It sits on the core's `io_rd`/`io_wr`/`mem_addr`/`dout`/`io_din` port and answers the core's I/O cycles. It provides an 8-bit LED register, a free-running 16-bit cycle counter, and a UART (TX with FIFO, single-byte RX holding register). It is the target side of the I/O strobes the core initiates.

---
 rtl/j1_io_responder_if.sv | 12 +
 rtl/j1_io_responder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_j1_io_responder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/j1_io_responder_if.sv
// Core-side I/O bus of the J1: strobes, address, write data and read-back data.
// The core drives the master side; the I/O responder is the slave.
interface j1_io_responder_if;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] mem_addr;
  logic [15:0] dout;
  logic [15:0] io_din;

  modport master (output io_rd, io_wr, mem_addr, dout, input io_din);
  modport slave  (input io_rd, io_wr, mem_addr, dout, output io_din);
endinterface

// File: rtl/j1_io_responder.sv
// J1 I/O-space responder: LED register, free-running cycle counter and a UART
// with a transmit FIFO and a single-byte receive holding register.
module j1_io_responder #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TX_DEPTH     = 4
) (
  input  logic              clk,
  input  logic              resetq,
  j1_io_responder_if.slave  bus,
  input  logic              uart_rx,
  output logic              uart_tx,
  output logic [7:0]        leds
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   PTR_ONE  = 1;
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [15:0] ADDR_LEDS = 16'h0000;
  localparam logic [15:0] ADDR_UART = 16'h1000;
  localparam logic [15:0] ADDR_STAT = 16'h2000;
  localparam logic [15:0] ADDR_CNT  = 16'h4000;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic sel_leds, sel_uart, sel_stat, sel_cnt;
  assign sel_leds = (bus.mem_addr == ADDR_LEDS);
  assign sel_uart = (bus.mem_addr == ADDR_UART);
  assign sel_stat = (bus.mem_addr == ADDR_STAT);
  assign sel_cnt  = (bus.mem_addr == ADDR_CNT);

  // ---------------- LEDs and counter ----------------
  logic [7:0]  leds_reg;
  logic [15:0] counter_reg;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      leds_reg    <= 8'h00;
      counter_reg <= 16'h0000;
    end else begin
      if (bus.io_wr && sel_leds)
        leds_reg <= bus.dout[7:0];
      // A load replaces the increment on that edge.
      if (bus.io_wr && sel_cnt)
        counter_reg <= bus.dout;
      else
        counter_reg <= counter_reg + 16'd1;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic        fifo_full, fifo_empty, fifo_push, tx_pop;
  logic [7:0]  fifo_rdata;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign fifo_push  = bus.io_wr && sel_uart && !fifo_full;
  assign fifo_rdata = fifo_mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (fifo_push)
      fifo_mem[wr_ptr_reg[AW-1:0]] <= bus.dout[7:0];
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (fifo_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (tx_pop)    rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t     tx_state_reg, tx_state_next;
  logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]    tx_bit_reg, tx_bit_next;
  logic [7:0]    tx_shift_reg, tx_shift_next;
  logic          uart_tx_reg, tx_line_next;
  logic          tx_bit_end, tx_busy;

  assign tx_bit_end = (tx_cnt_reg == CNT_BIT);
  assign tx_busy    = (tx_state_reg != TX_IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= 3'd0;
      tx_shift_reg <= 8'h00;
      uart_tx_reg  <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      uart_tx_reg  <= tx_line_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg + CNT_ONE;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    case (tx_state_reg)
      TX_IDLE: begin
        tx_cnt_next = '0;
        if (tx_pop) begin
          tx_shift_next = fifo_rdata;
          tx_state_next = TX_START;
        end
      end
      TX_START: if (tx_bit_end) begin
        tx_cnt_next   = '0;
        tx_bit_next   = 3'd0;
        tx_state_next = TX_DATA;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_cnt_next   = '0;
        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
        tx_bit_next   = tx_bit_reg + 3'd1;
        if (tx_bit_reg == 3'd7) tx_state_next = TX_STOP;
      end
      TX_STOP: if (tx_bit_end) begin
        tx_cnt_next = '0;
        // Chain straight into the next frame when a byte is waiting.
        if (tx_pop) begin
          tx_shift_next = fifo_rdata;
          tx_state_next = TX_START;
        end else begin
          tx_state_next = TX_IDLE;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_pop = !fifo_empty &&
             ((tx_state_reg == TX_IDLE) || (tx_state_reg == TX_STOP && tx_bit_end));
    case (tx_state_next)
      TX_START: tx_line_next = 1'b0;
      TX_DATA:  tx_line_next = tx_shift_next[0];
      default:  tx_line_next = 1'b1;
    endcase
  end

  // ---------------- RX synchronizer and FSM ----------------
  logic [1:0]    rx_sync_reg;
  logic          rx_s;
  rx_state_t     rx_state_reg, rx_state_next;
  logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]    rx_bit_reg, rx_bit_next;
  logic [7:0]    rx_shift_reg, rx_shift_next;
  logic          rx_bit_end, rx_done;

  assign rx_s       = rx_sync_reg[1];
  assign rx_bit_end = (rx_cnt_reg == CNT_BIT);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_sync_reg  <= 2'b11;
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= 3'd0;
      rx_shift_reg <= 8'h00;
    end else begin
      rx_sync_reg  <= {rx_sync_reg[0], uart_rx};
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg + CNT_ONE;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    case (rx_state_reg)
      RX_IDLE: begin
        rx_cnt_next = '0;
        if (!rx_s) rx_state_next = RX_START;
      end
      RX_START: if (rx_cnt_reg == CNT_HALF) begin
        // Re-check mid start bit; a high line here was only a glitch.
        rx_cnt_next   = '0;
        rx_bit_next   = 3'd0;
        rx_state_next = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_bit_end) begin
        rx_cnt_next   = '0;
        rx_shift_next = {rx_s, rx_shift_reg[7:1]};
        rx_bit_next   = rx_bit_reg + 3'd1;
        if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
      end
      RX_STOP: if (rx_bit_end) begin
        rx_cnt_next   = '0;
        rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_done = (rx_state_reg == RX_STOP) && rx_bit_end && rx_s;
  end

  // ---------------- RX holding register and flags ----------------
  logic [7:0] rx_data_reg;
  logic       rx_valid_reg, rx_overrun_reg;
  logic       rd_data, rd_stat;

  assign rd_data = bus.io_rd && sel_uart;
  assign rd_stat = bus.io_rd && sel_stat;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_data_reg    <= 8'h00;
      rx_valid_reg   <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end else begin
      if (rx_done) begin
        rx_data_reg  <= rx_shift_reg;
        rx_valid_reg <= 1'b1;
      end else if (rd_data) begin
        rx_valid_reg <= 1'b0;
      end
      // A byte landing on the same edge as a data read is not an overrun.
      if (rx_done && rx_valid_reg && !rd_data)
        rx_overrun_reg <= 1'b1;
      else if (rd_stat)
        rx_overrun_reg <= 1'b0;
    end
  end

  // ---------------- Read mux ----------------
  logic [15:0] io_din_w;

  always_comb begin
    io_din_w = 16'h0000;
    if (sel_leds)      io_din_w = {8'h00, leds_reg};
    else if (sel_uart) io_din_w = {8'h00, rx_data_reg};
    else if (sel_stat) io_din_w = {12'h000, rx_overrun_reg, tx_busy, rx_valid_reg, fifo_full};
    else if (sel_cnt)  io_din_w = counter_reg;
  end

  assign bus.io_din = io_din_w;
  assign uart_tx    = uart_tx_reg;
  assign leds       = leds_reg;
endmodule

// File: tb/tb_j1_io_responder.sv
// Directed bench for j1_io_responder: LEDs, decode, counter, UART TX/FIFO and RX.
module tb_j1_io_responder;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk     = 1'b0;
  logic       resetq  = 1'b0;
  logic       uart_rx = 1'b1;
  logic       uart_tx;
  logic [7:0] leds;

  int checks   = 0;
  int failures = 0;

  logic cap [200];

  j1_io_responder_if bus();

  j1_io_responder #(.CLKS_PER_BIT(CPB), .TX_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .resetq  (resetq),
    .bus     (bus),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .leds    (leds)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    bus.io_wr = 1'b1; bus.mem_addr = addr; bus.dout = data;
    @(posedge clk); #1;
    bus.io_wr = 1'b0;
    $display("WR  addr=%h data=%h", addr, data);
  endtask

  task automatic bus_read(input logic [15:0] addr, input logic side, output logic [15:0] data);
    @(negedge clk);
    bus.mem_addr = addr; bus.io_rd = side;
    #1 data = bus.io_din;
    @(posedge clk); #1;
    bus.io_rd = 1'b0;
    $display("RD  addr=%h rd=%0b data=%h", addr, side, data);
  endtask

  task automatic peek(input logic [15:0] addr, output logic [15:0] data);
    bus.mem_addr = addr;
    #1 data = bus.io_din;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rx = fr[i];
      repeat (CPB - 1) @(negedge clk);
    end
    $display("RXF byte=%h", b);
  endtask

  task automatic test_reset();
    logic [15:0] v;
    bus_write(16'h0000, 16'h00A5);
    bus_write(16'h1000, 16'h0000);
    repeat (8) @(posedge clk); #1;
    checks++;
    if (uart_tx !== 1'b0) begin failures++; $display("FAIL reset_pre_tx got=%b exp=0", uart_tx); end
    #2 resetq = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
    checks++;
    if (leds !== 8'h00) begin failures++; $display("FAIL reset_leds got=%h exp=00", leds); end
    peek(16'h4000, v);
    checks++;
    if (v !== 16'h0000) begin failures++; $display("FAIL reset_counter got=%h exp=0000", v); end
    repeat (2) @(negedge clk);
    resetq = 1'b1;
    @(posedge clk); #1;
    peek(16'h0000, v);
    checks++;
    if (v !== 16'h0000) begin failures++; $display("FAIL reset_rd_leds got=%h exp=0000", v); end
    peek(16'h1000, v);
    checks++;
    if (v !== 16'h0000) begin failures++; $display("FAIL reset_rd_uart got=%h exp=0000", v); end
    peek(16'h2000, v);
    checks++;
    if (v !== 16'h0000) begin failures++; $display("FAIL reset_rd_stat got=%h exp=0000", v); end
  endtask

  task automatic test_leds();
    logic [15:0] v;
    bus_write(16'h0000, 16'h1234);
    checks++;
    if (leds !== 8'h34) begin failures++; $display("FAIL leds_write got=%h exp=34", leds); end
    bus_read(16'h0000, 1'b1, v);
    checks++;
    if (v !== 16'h0034) begin failures++; $display("FAIL leds_read got=%h exp=0034", v); end
    bus_write(16'h0800, 16'hFFFF);
    checks++;
    if (leds !== 8'h34) begin failures++; $display("FAIL unmapped_write got=%h exp=34", leds); end
    bus_read(16'h0800, 1'b1, v);
    checks++;
    if (v !== 16'h0000) begin failures++; $display("FAIL unmapped_read got=%h exp=0000", v); end
    bus_read(16'h0001, 1'b1, v);
    checks++;
    if (v !== 16'h0000) begin failures++; $display("FAIL partial_addr got=%h exp=0000", v); end
  endtask

  task automatic test_tx();
    logic [15:0] st;
    logic [9:0]  fr;
    fr = {1'b1, 8'h55, 1'b0};
    bus_write(16'h1000, 16'h0055);
    checks++;
    if (uart_tx !== 1'b1) begin failures++; $display("FAIL tx_before_pop got=%b exp=1", uart_tx); end
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      peek(16'h2000, st);
      checks++;
      if (uart_tx !== fr[j / 4]) begin
        failures++; $display("FAIL tx_line cyc=%0d got=%b exp=%b", j, uart_tx, fr[j / 4]);
      end
      checks++;
      if (st[2] !== 1'b1) begin failures++; $display("FAIL tx_busy cyc=%0d got=%b exp=1", j, st[2]); end
    end
    @(posedge clk); #1;
    peek(16'h2000, st);
    checks++;
    if (st !== 16'h0000) begin failures++; $display("FAIL tx_done_stat got=%h exp=0000", st); end
    checks++;
    if (uart_tx !== 1'b1) begin failures++; $display("FAIL tx_idle got=%b exp=1", uart_tx); end
  endtask

  task automatic test_fifo_full();
    logic [15:0] st;
    logic [9:0]  fr;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          bus_write(16'h1000, 16'(16'h0041 + i));
          if (i == 3) begin
            peek(16'h2000, st);
            checks++;
            if (st[0] !== 1'b0) begin failures++; $display("FAIL fifo_not_full got=%b exp=0", st[0]); end
          end
          if (i == 4) begin
            peek(16'h2000, st);
            checks++;
            if (st[0] !== 1'b1) begin failures++; $display("FAIL fifo_full got=%b exp=1", st[0]); end
          end
        end
      end
      begin
        @(negedge clk);
        @(posedge clk);
        for (int j = 0; j < 200; j++) begin
          @(posedge clk); #1;
          cap[j] = uart_tx;
        end
      end
    join
    for (int f = 0; f < 5; f++) begin
      fr = {1'b1, 8'(8'h41 + f), 1'b0};
      for (int j = 0; j < 40; j++) begin
        checks++;
        if (cap[f * 40 + j] !== fr[j / 4]) begin
          failures++;
          $display("FAIL fifo_line frame=%0d cyc=%0d got=%b exp=%b", f, j, cap[f * 40 + j], fr[j / 4]);
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (uart_tx !== 1'b1) begin failures++; $display("FAIL fifo_dropped_byte got=%b exp=1", uart_tx); end
    peek(16'h2000, st);
    checks++;
    if (st !== 16'h0000) begin failures++; $display("FAIL fifo_drained got=%h exp=0000", st); end
  endtask

  task automatic test_rx();
    logic [15:0] v;
    @(negedge clk); uart_rx = 1'b0;
    @(negedge clk); uart_rx = 1'b1;
    repeat (8) @(posedge clk); #1;
    peek(16'h2000, v);
    checks++;
    if (v !== 16'h0000) begin failures++; $display("FAIL rx_glitch_stat got=%h exp=0000", v); end
    peek(16'h1000, v);
    checks++;
    if (v !== 16'h0000) begin failures++; $display("FAIL rx_glitch_data got=%h exp=0000", v); end

    send_byte(8'hC3);
    repeat (3) @(posedge clk); #1;
    peek(16'h2000, v);
    checks++;
    if (v !== 16'h0002) begin failures++; $display("FAIL rx_valid_stat got=%h exp=0002", v); end
    bus_read(16'h1000, 1'b1, v);
    checks++;
    if (v !== 16'h00C3) begin failures++; $display("FAIL rx_data got=%h exp=00c3", v); end
    peek(16'h2000, v);
    checks++;
    if (v !== 16'h0000) begin failures++; $display("FAIL rx_cleared got=%h exp=0000", v); end

    send_byte(8'h5A);
    send_byte(8'hA7);
    repeat (3) @(posedge clk); #1;
    peek(16'h2000, v);
    checks++;
    if (v !== 16'h000A) begin failures++; $display("FAIL rx_overrun_stat got=%h exp=000a", v); end
    peek(16'h1000, v);
    checks++;
    if (v !== 16'h00A7) begin failures++; $display("FAIL rx_overwrite got=%h exp=00a7", v); end
    bus_read(16'h2000, 1'b1, v);
    checks++;
    if (v !== 16'h000A) begin failures++; $display("FAIL rx_stat_read got=%h exp=000a", v); end
    peek(16'h2000, v);
    checks++;
    if (v !== 16'h0002) begin failures++; $display("FAIL rx_overrun_clr got=%h exp=0002", v); end
    bus_read(16'h1000, 1'b1, v);
    checks++;
    if (v !== 16'h00A7) begin failures++; $display("FAIL rx_data2 got=%h exp=00a7", v); end
    peek(16'h2000, v);
    checks++;
    if (v !== 16'h0000) begin failures++; $display("FAIL rx_final got=%h exp=0000", v); end
  endtask

  task automatic test_counter();
    logic [15:0] v;
    logic [15:0] exp_v [4];
    exp_v[0] = 16'hFFFE; exp_v[1] = 16'hFFFF; exp_v[2] = 16'h0000; exp_v[3] = 16'h0001;
    bus_write(16'h4000, 16'hFFFE);
    for (int i = 0; i < 4; i++) begin
      bus_read(16'h4000, 1'b1, v);
      checks++;
      if (v !== exp_v[i]) begin failures++; $display("FAIL counter_wrap step=%0d got=%h exp=%h", i, v, exp_v[i]); end
    end
  endtask

  initial begin
    bus.io_rd = 1'b0; bus.io_wr = 1'b0; bus.mem_addr = 16'h0000; bus.dout = 16'h0000;
    resetq = 1'b0;
    repeat (3) @(negedge clk);
    resetq = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_leds();
    test_tx();
    test_fifo_full();
    test_rx();
    test_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
